// File: rtl/tc_rn_acc.sv
// tc_rn_acc: handshaked K-reduction network with multi-beat tile accumulation.
// Stage R registers the per-lane K sums of an accepted beat; stage A accumulates
// them across beats until a last-tagged beat closes the tile and presents it.
// Optional feature macro: TC_RN_ACC_SAT_EN (saturating lane adds plus out_sat flag);
// without it lane adds wrap modulo 2^DW_ACC and out_sat is tied low.
module tc_rn_acc #(
   parameter int unsigned TILE_M  = 4,
   parameter int unsigned TILE_K  = 8,
   parameter int unsigned TILE_N  = 4,
   parameter int unsigned DW_DATA = 8,
   parameter int unsigned DW_ACC  = 24,
   parameter int unsigned DW_CNT  = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic                                   in_last,
   input  logic [TILE_M*TILE_K*TILE_N*DW_DATA-1:0] in_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [TILE_M*TILE_N*DW_ACC-1:0]        out_data,
   output logic [DW_CNT-1:0]                      out_cnt,
   output logic                                   out_sat
);

   localparam int unsigned LANES  = TILE_M * TILE_N;
   localparam int unsigned DW_RED = DW_DATA + $clog2(TILE_K);

   // IDLE: empty, nothing held. ACCUM: partial tile. HOLD: closed tile presented.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [LANES-1:0][DW_RED-1:0] red_sum;

   logic                         r_valid_q, r_valid_d;
   logic                         r_last_q, r_last_d;
   logic [LANES-1:0][DW_RED-1:0] r_sum_q, r_sum_d;

   logic [LANES-1:0][DW_ACC-1:0] acc_q, acc_d;
   logic [DW_CNT-1:0]            cnt_q, cnt_d;
   logic [1:0]                   state_q, state_d;

   logic                         in_hs, out_hs, a_move, fresh;
   logic [DW_ACC-1:0]            ext;

`ifdef TC_RN_ACC_SAT_EN
   logic                         sat_q, sat_d;
   logic                         clip;
   logic [DW_ACC:0]              wide;
`endif

   // Handshake and flow control; in_ready depends combinationally on out_ready.
   always_comb begin
      out_valid = (state_q == ST_HOLD);
      a_move    = r_valid_q && (!out_valid || out_ready);
      out_hs    = out_valid && out_ready;
      in_ready  = !r_valid_q || a_move;
      in_hs     = in_valid && in_ready;
      // HOLD only moves together with an output handshake, so it also restarts.
      fresh     = (state_q != ST_ACCUM);
   end

   // Exact per-lane sum over K of sign-extended products.
   always_comb begin
      red_sum = '0;
      for (int m = 0; m < TILE_M; m++) begin
         for (int n = 0; n < TILE_N; n++) begin
            for (int k = 0; k < TILE_K; k++) begin
               red_sum[m*TILE_N+n] = red_sum[m*TILE_N+n] +
                  DW_RED'($signed(in_data[((m*TILE_K+k)*TILE_N+n)*DW_DATA +: DW_DATA]));
            end
         end
      end
   end

   // Stage R next state: load on input handshake, empty when A takes it.
   always_comb begin
      r_valid_d = r_valid_q;
      r_last_d  = r_last_q;
      r_sum_d   = r_sum_q;
      if (in_hs) begin
         r_valid_d = 1'b1;
         r_last_d  = in_last;
         r_sum_d   = red_sum;
      end else if (a_move) begin
         r_valid_d = 1'b0;
      end
   end

   // Stage A next state: start or extend a tile, close it on a last beat.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      ext     = '0;
`ifdef TC_RN_ACC_SAT_EN
      sat_d   = sat_q;
      clip    = 1'b0;
      wide    = '0;
`endif
      if (a_move) begin
         for (int l = 0; l < LANES; l++) begin
            ext = DW_ACC'($signed(r_sum_q[l]));
            if (fresh) begin
               acc_d[l] = ext;
            end else begin
`ifdef TC_RN_ACC_SAT_EN
               wide = {acc_q[l][DW_ACC-1], acc_q[l]} + {ext[DW_ACC-1], ext};
               if (wide[DW_ACC] != wide[DW_ACC-1]) begin
                  clip     = 1'b1;
                  acc_d[l] = wide[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}}
                                          : {1'b0, {(DW_ACC-1){1'b1}}};
               end else begin
                  acc_d[l] = wide[DW_ACC-1:0];
               end
`else
               acc_d[l] = acc_q[l] + ext;
`endif
            end
         end
         if (fresh) begin
            cnt_d = DW_CNT'(1);
         end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
         end
`ifdef TC_RN_ACC_SAT_EN
         sat_d = fresh ? 1'b0 : (sat_q | clip);
`endif
         state_d = r_last_q ? ST_HOLD : ST_ACCUM;
      end else if (out_hs) begin
         state_d = ST_IDLE;
      end
   end

   // State registers for both stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
         r_sum_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         state_q   <= ST_IDLE;
`ifdef TC_RN_ACC_SAT_EN
         sat_q     <= 1'b0;
`endif
      end else begin
         r_valid_q <= r_valid_d;
         r_last_q  <= r_last_d;
         r_sum_q   <= r_sum_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
`ifdef TC_RN_ACC_SAT_EN
         sat_q     <= sat_d;
`endif
      end
   end

   // Accumulator contents are frozen while a tile is held, so they drive out_data directly.
   always_comb begin
      out_data = acc_q;
      out_cnt  = cnt_q;
`ifdef TC_RN_ACC_SAT_EN
      out_sat  = sat_q;
`else
      out_sat  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_tc_rn_acc.sv
// tb_tc_rn_acc: table-driven tile vectors plus directed multi-cycle sequences.
// A second instance with DW_ACC=12 shares all inputs to exercise the width limits.
module tb_tc_rn_acc;

   localparam int IN_W  = 4 * 8 * 4 * 8;
   localparam int OUT_W = 16 * 24;
   localparam int O12_W = 16 * 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_last, out_ready;
   logic [IN_W-1:0]  in_data;
   logic             in_ready, out_valid, out_sat;
   logic [OUT_W-1:0] out_data;
   logic [15:0]      out_cnt;
   logic             in_ready12, out_valid12, out_sat12;
   logic [O12_W-1:0] out_data12;
   logic [15:0]      out_cnt12;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int n;
      int v0, v1, v2;
      int exp;
      int exp12;
      int sat12;
      int cnt;
   } vec_t;

   vec_t tbl[6];

   tc_rn_acc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_cnt(out_cnt), .out_sat(out_sat)
   );

   tc_rn_acc #(.DW_ACC(12)) dut12 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12), .in_last(in_last),
      .in_data(in_data), .out_valid(out_valid12), .out_ready(out_ready),
      .out_data(out_data12), .out_cnt(out_cnt12), .out_sat(out_sat12)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [IN_W-1:0] fill(input int v);
      logic [IN_W-1:0] r;
      r = '0;
      for (int i = 0; i < 128; i++) r[i*8 +: 8] = 8'(v);
      return r;
   endfunction

   function automatic longint lane(input int i);
      logic signed [23:0] s;
      s = out_data[i*24 +: 24];
      return longint'(s);
   endfunction

   function automatic longint lane12(input int i);
      logic signed [11:0] s;
      s = out_data12[i*12 +: 12];
      return longint'(s);
   endfunction

   function automatic int pick(input vec_t v, input int b);
      if (b == 0) return v.v0;
      if (b == 1) return v.v1;
      return v.v2;
   endfunction

   // Presents one beat and waits (bounded) until it is accepted; returns just after the edge.
   task automatic send(input logic [IN_W-1:0] d, input logic last);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_val("send_accept", longint'(acc), 1);
   endtask

   // Called right after the edge that accepted a last beat (out_ready high):
   // checks two-cycle latency and the presented tile, leaves time at that point.
   task automatic expect_tile(input string name, input longint exp, input longint cnt);
      check_val({name, "_lat_early"}, longint'(out_valid), 0);
      @(posedge clk);
      #1;
      check_val({name, "_valid"}, longint'(out_valid), 1);
      for (int i = 0; i < 16; i++) check_val({name, "_lane"}, lane(i), exp);
      check_val({name, "_cnt"}, longint'(out_cnt), cnt);
      check_val({name, "_sat"}, longint'(out_sat), 0);
   endtask

   logic [IN_W-1:0] vd;
   int              accepts;
   longint          got[$];

   initial begin
      tbl[0] = '{n: 1, v0: 1,    v1: 0,    v2: 0,   exp: 8,     exp12: 8,     sat12: 0, cnt: 1};
      tbl[1] = '{n: 3, v0: 2,    v1: -1,   v2: 3,   exp: 32,    exp12: 32,    sat12: 0, cnt: 3};
`ifdef TC_RN_ACC_SAT_EN
      tbl[2] = '{n: 3, v0: 127,  v1: 127,  v2: 127, exp: 3048,  exp12: 2047,  sat12: 1, cnt: 3};
`else
      tbl[2] = '{n: 3, v0: 127,  v1: 127,  v2: 127, exp: 3048,  exp12: -1048, sat12: 0, cnt: 3};
`endif
      tbl[3] = '{n: 1, v0: -128, v1: 0,    v2: 0,   exp: -1024, exp12: -1024, sat12: 0, cnt: 1};
      tbl[4] = '{n: 2, v0: -100, v1: -100, v2: 0,   exp: -1600, exp12: -1600, sat12: 0, cnt: 2};
      tbl[5] = '{n: 1, v0: -1,   v1: 0,    v2: 0,   exp: -8,    exp12: -8,    sat12: 0, cnt: 1};

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #1;
      check_val("rst_in_ready", longint'(in_ready), 1);
      check_val("rst_in_ready12", longint'(in_ready12), 1);
      check_val("rst_out_valid", longint'(out_valid), 0);
      check_val("rst_out_data_zero", longint'(out_data == '0), 1);
      check_val("rst_out_cnt", longint'(out_cnt), 0);
      check_val("rst_out_sat", longint'(out_sat), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_rst_in_ready", longint'(in_ready), 1);
      check_val("post_rst_out_valid", longint'(out_valid), 0);

      // Table-driven tiles, unstalled.
      for (int t = 0; t < 6; t++) begin
         for (int b = 0; b < tbl[t].n; b++) send(fill(pick(tbl[t], b)), b == tbl[t].n - 1);
         expect_tile($sformatf("tbl%0d", t), tbl[t].exp, tbl[t].cnt);
         check_val($sformatf("tbl%0d_valid12", t), longint'(out_valid12), 1);
         for (int i = 0; i < 16; i++)
            check_val($sformatf("tbl%0d_lane12", t), lane12(i), tbl[t].exp12);
         check_val($sformatf("tbl%0d_cnt12", t), longint'(out_cnt12), tbl[t].cnt);
         check_val($sformatf("tbl%0d_sat12", t), longint'(out_sat12), tbl[t].sat12);
         @(posedge clk);
         #1;
         check_val($sformatf("tbl%0d_drained", t), longint'(out_valid), 0);
      end

      // Varied products: (m,k,n) = 4m+n-k, lane sum = 8(4m+n)-28.
      vd = '0;
      for (int m = 0; m < 4; m++)
         for (int k = 0; k < 8; k++)
            for (int n = 0; n < 4; n++) vd[((m*8+k)*4+n)*8 +: 8] = 8'(4*m + n - k);
      send(vd, 1'b1);
      check_val("vary_lat_early", longint'(out_valid), 0);
      @(posedge clk);
      #1;
      check_val("vary_valid", longint'(out_valid), 1);
      for (int i = 0; i < 16; i++) begin
         check_val($sformatf("vary_lane%0d", i), lane(i), 8 * i - 28);
         check_val($sformatf("vary12_lane%0d", i), lane12(i), 8 * i - 28);
      end
      @(posedge clk);
      #1;

      // Reset mid-tile discards the partial sum.
      send(fill(5), 1'b0);
      send(fill(5), 1'b0);
      rst = 1'b0;
      #1;
      check_val("midrst_in_ready", longint'(in_ready), 1);
      check_val("midrst_cnt", longint'(out_cnt), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send(fill(1), 1'b1);
      expect_tile("midrst", 8, 1);
      @(posedge clk);
      #1;

      // Output handshake coincides with a non-last move: new tile must start fresh.
      out_ready = 1'b0;
      send(fill(2), 1'b1);
      send(fill(3), 1'b0);
      check_val("sim_hold_valid", longint'(out_valid), 1);
      check_val("sim_hold_lane", lane(0), 16);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("sim_after_hs_valid", longint'(out_valid), 0);
      send(fill(1), 1'b1);
      expect_tile("sim", 32, 2);
      @(posedge clk);
      #1;

      // Back-pressure: four single-beat tiles while the output stalls for 5 cycles.
      accepts = 0;
      got.delete();
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(fill(i + 1), 1'b1);
               accepts++;
            end
         end
         begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check_val("bp_accepts", longint'(accepts), 2);
            check_val("bp_in_ready", longint'(in_ready), 0);
            check_val("bp_hold_valid", longint'(out_valid), 1);
            check_val("bp_hold_lane", lane(0), 8);
            check_val("bp_hold_cnt", longint'(out_cnt), 1);
            out_ready = 1'b1;
         end
         begin
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               if (out_valid && out_ready) got.push_back(lane(15));
            end
         end
      join
      check_val("bp_count", longint'(got.size()), 4);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("bp_out%0d", i), (i < got.size()) ? got[i] : -99999, 8 * (i + 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tc_rn_acc.md
# tc_rn_acc

Pipelined, handshaked reduction network with K-tile accumulation for the tensor core datapath. Each accepted beat carries TILE_M×TILE_K×TILE_N signed products. The block reduces over K for every (m,n) lane, then accumulates the lane sums across successive beats until a beat tagged `in_last` arrives. It then presents the TILE_M×TILE_N accumulated tile downstream. It is the accumulating, flow-controlled successor of the per-row adder-tree reduction network and sits between the multiplier array and the output writeback.

## Interface
- `TILE_M`, 4, number of output rows.
- `TILE_K`, 8, reduction depth per beat; power of two, ≥2.
- `TILE_N`, 4, number of output columns.
- `DW_DATA`, 8, signed product width.
- `DW_ACC`, 24, signed accumulator width per lane; ≥ DW_DATA+log2(TILE_K).
- `DW_CNT`, 16, beat-counter width.
- `clk` input 1: single clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts the beat this cycle.
- `in_last` input 1: the beat closes the current output tile.
- `in_data` input TILE_M·TILE_K·TILE_N·DW_DATA: product (m,k,n) at bit offset ((m·TILE_K+k)·TILE_N+n)·DW_DATA.
- `out_valid` output 1: an accumulated tile is available.
- `out_ready` input 1: downstream accepts the tile.
- `out_data` output TILE_M·TILE_N·DW_ACC: lane (m,n) at offset (m·TILE_N+n)·DW_ACC.
- `out_cnt` output DW_CNT: number of beats accumulated into the presented tile.
- `out_sat` output 1: at least one lane clipped during this tile (always 0 when saturation is compiled out).

## Operation
- **Stage R (reduce register).** On input handshake (`in_valid && in_ready`), capture for each lane the sign-extended sum over k of product (m,k,n), computed exactly in DW_DATA+log2(TILE_K) bits. Also capture `in_last`. Set `r_valid`.
- **Stage A (accumulator).** Holds the per-lane accumulators, the `acc_empty` flag, the counter, and `out_valid`.
- **A advance condition.** A may take from R when `r_valid && (!out_valid || out_ready)`.
- **A update.**
  - If `acc_empty` or an output handshake occurs in the same cycle: acc = sext(r_sum) and cnt = 1.
  - Otherwise: acc = acc + sext(r_sum) and cnt = cnt+1. The counter saturates at 2^DW_CNT−1.
- **Closing a tile.** If the moved beat has last=1, A sets `out_valid`; `out_data`, `out_cnt` and `out_sat` then hold stable until `out_ready`.
- **State encoding.** IDLE (acc_empty, !out_valid) → ACCUM on a non-last move. IDLE or ACCUM → HOLD on a last move. HOLD → IDLE on output handshake without a move. HOLD → ACCUM or HOLD on output handshake with a simultaneous non-last or last move.
- **Input ready.** `in_ready = !r_valid || a_move`, a combinational path from `out_ready`.
- **Width rule.** Default arithmetic wraps modulo 2^DW_ACC (two's complement).
- **Empty input case.** `in_valid` low holds all state.

## Timing
- **Reset values.** `rst` low asynchronously clears all state. `out_valid`=0, `out_data`=0, `out_cnt`=0, `out_sat`=0, `r_valid`=0, acc_empty=1. `in_ready`=1 while `rst` is low and after release.
- **Latency.** Beat with `in_last` accepted at cycle t → `out_valid` high at t+2 when unstalled.
- **Throughput.** One beat per cycle. Single-beat tiles with `out_ready` high give back-to-back `out_valid`.
- **Back-pressure.** With `out_valid && !out_ready`, R fills and `in_ready` falls the cycle after one further beat is accepted. No beat is lost or duplicated.
- **Reset mid-tile.** Discards the partial accumulation and any held output; the next beat starts a fresh tile.

## Configuration
- `TC_RN_ACC_SAT_EN`
  - Defined: each lane add saturates to [−2^(DW_ACC−1), 2^(DW_ACC−1)−1], and any clip sets `out_sat` for that tile. `out_sat` clears when the next tile starts.
  - Undefined: accumulation wraps and `out_sat` is tied to 0.

## Test plan
- **Single beat.** Defaults, all products 1, `in_last`=1 at t → at t+2 every lane = 8, `out_cnt`=1, `out_sat`=0.
- **Three-beat accumulation.** All products 2, then −1, then 3; last on the third beat → every lane = 16+(−8)+24 = 32, `out_cnt`=3, presented 2 cycles after the third accept.
- **Back-pressure.** Hold `out_ready`=0 for 5 cycles while streaming single-beat tiles of values 1,2,3,4 → `in_ready` drops after one extra accept. The outputs emerge in order as 8, 16, 24, 32 with none dropped.
- **Width limits, DW_ACC=12.** All products 127, three beats with last on the third (3048 per lane):
  - Wrap build: lanes = −1048, `out_sat`=0.
  - With `TC_RN_ACC_SAT_EN`: lanes = 2047, `out_sat`=1.
  - Negative check: all products −128, single beat → lanes = −1024.
- **Reset mid-tile.** Two non-last beats of value 5, pull `rst` low one cycle, then one last beat of value 1 → lanes = 8, `out_cnt`=1.
- **Simultaneous events.** Output handshake in the same cycle a non-last beat moves into A → the new tile starts at that beat's sum and `out_cnt`=1; no carry-over from the previous tile.
